// File: rtl/timer_share_pkg.sv
// timer_share_pkg: FSM state encoding shared by the timer arbiter.
package timer_share_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..DIV_MAX, registered tick aligned with the cycle where count==DIV_MAX.
module tick_prescaler #(
    parameter int DIV_MAX = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [W-1:0] LAST = W'(DIV_MAX);
    logic [W-1:0] cnt, nxt;
    assign nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= nxt;
            tick <= (nxt == LAST);
        end
    end
endmodule

// File: rtl/timer_share_arbiter.sv
// timer_share_arbiter: round-robin sharing of one prescaled timer among NUM_REQ requesters.
// Define TIMER_SHARE_STATUS_EN to expose the live remaining count and owner index.
module timer_share_arbiter
    import timer_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIV_MAX = 100,
    parameter int CNT_W   = 8,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_ticks,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
`ifdef TIMER_SHARE_STATUS_EN
    output logic [CNT_W-1:0]         remaining,
    output logic [IW-1:0]            owner,
`endif
    output logic                     tick
);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t state, state_nxt;
    logic [IW-1:0] rr, sel;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic [CNT_W-1:0] ticks_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign ticks_arr[i] = req_ticks[i*CNT_W +: CNT_W];
    end

    // Nearest set bit after p wins: scan farthest to nearest so the nearest overrides.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] p);
        rr_pick = p;
        for (int i = NUM_REQ; i >= 1; i--) begin
            int idx;
            idx = (int'(p) + i) % NUM_REQ;
            if (r[IW'(idx)])
                rr_pick = IW'(idx);
        end
    endfunction

    assign sel = rr_pick(req, rr);

    tick_prescaler #(.DIV_MAX(DIV_MAX)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (state_nxt != RUN),
        .en   (state == RUN),
        .tick (tick)
    );

    // Abort is tested before expiry so it wins over a coincident final tick.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                state_nxt = |req ? RUN : IDLE;
                rem_nxt   = |req ? ticks_arr[sel] : '0;
            end
            RUN: begin
                state_nxt = !req[rr] ? IDLE
                          : (rem == '0 || (tick && rem == CNT_W'(1))) ? DONE : RUN;
                rem_nxt   = (state_nxt != RUN) ? '0 : tick ? rem - 1'b1 : rem;
            end
            default: begin
                state_nxt = IDLE;
                rem_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rr    <= IW'(NUM_REQ - 1);
            rem   <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            rr    <= (state == IDLE && |req) ? sel : rr;
            gnt   <= (state_nxt == RUN) ? ONE << ((state == IDLE) ? sel : rr) : '0;
            done  <= (state_nxt == DONE) ? ONE << rr : '0;
            busy  <= (state_nxt != IDLE);
        end
    end

`ifdef TIMER_SHARE_STATUS_EN
    assign remaining = rem;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            owner <= '0;
        else if (state == IDLE && |req)
            owner <= sel;
    end
`endif
endmodule

// File: tb/tb_timer_share_arbiter.sv
// tb_timer_share_arbiter: directed vectors plus a per-cycle check against an elapsed-time model.
module tb_timer_share_arbiter;
    localparam int N = 4;
    localparam int D = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_ticks = '0;
    logic [N-1:0] gnt, done;
    logic         busy, tick;
`ifdef TIMER_SHARE_STATUS_EN
    logic [W-1:0] remaining;
    logic [1:0]   owner;
`endif

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    timer_share_arbiter #(.NUM_REQ(N), .DIV_MAX(D), .CNT_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_ticks(req_ticks),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
`ifdef TIMER_SHARE_STATUS_EN
        .remaining(remaining),
        .owner    (owner),
`endif
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an owner holds the timer for a number of elapsed cycles fixed by its tick count.
    int m_own = -1, m_e = 0, m_k = 0, m_ptr = N - 1, m_last = 0, m_didx = 0;
    bit m_done = 0;

    task automatic model_reset;
        m_own = -1; m_e = 0; m_k = 0; m_ptr = N - 1; m_last = 0; m_done = 0;
    endtask

    task automatic model_step;
        logic [N-1:0] rq;
        int pick;
        rq = req;
        pick = -1;
        if (m_done) begin
            m_done = 0;
        end else if (m_own >= 0) begin
            if (!rq[m_own[1:0]]) begin
                m_own = -1;
            end else begin
                m_e++;
                if (m_e == ((m_k == 0) ? 1 : m_k * (D + 1))) begin
                    m_done = 1;
                    m_didx = m_own;
                    m_own = -1;
                end
            end
        end else if (rq != 0) begin
            for (int i = 1; i <= N; i++) begin
                int idx;
                idx = (m_ptr + i) % N;
                if (pick < 0 && rq[idx[1:0]])
                    pick = idx;
            end
            m_own = pick; m_ptr = pick; m_last = pick; m_e = 0;
            m_k = int'(req_ticks[pick*W +: W]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset)
                model_step();
            @(negedge clk);
            if (!reset) begin
                model_reset();
            end else begin
                chk("m_gnt", int'(gnt), (m_own >= 0) ? (1 << m_own) : 0);
                chk("m_done", int'(done), m_done ? (1 << m_didx) : 0);
                chk("m_busy", int'(busy), int'(m_own >= 0 || m_done));
                chk("m_tick", int'(tick), int'(m_own >= 0 && m_k > 0 && (m_e + 1) % (D + 1) == 0));
`ifdef TIMER_SHARE_STATUS_EN
                chk("m_remaining", int'(remaining), (m_own >= 0) ? m_k - m_e / (D + 1) : 0);
                chk("m_owner", int'(owner), m_last);
`endif
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic start_seq;
        reset = 1'b0;
        req = '0;
        req_ticks = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 cyc = 0;
    endtask

    initial begin
        // Reset mid-RUN, on a tick cycle
        start_seq();
        req = 4'b0001;
        req_ticks[7:0] = 8'd5;
        adv(4);
        chk("t1_tick_before", int'(tick), 1);
        chk("t1_gnt_before", int'(gnt), 1);
        #1 reset = 1'b0;
        #1;
        chk("t1_gnt_async", int'(gnt), 0);
        chk("t1_done_async", int'(done), 0);
        chk("t1_busy_async", int'(busy), 0);
        chk("t1_tick_async", int'(tick), 0);
        req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        adv(2);
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_gnt", int'(gnt), 0);
        req = 4'b0011;
        adv(1);
        chk("t1_first_prio", int'(gnt), 1);
        req = '0;
        adv(3);

        // Single requester, two ticks
        start_seq();
        req = 4'b0001;
        req_ticks[7:0] = 8'd2;
        for (int c = 1; c <= 10; c++) begin
            adv(1);
            chk("t2_gnt", int'(gnt[0]), int'(c >= 1 && c <= 8));
            chk("t2_tick", int'(tick), int'(c == 4 || c == 8));
            chk("t2_done", int'(done[0]), int'(c == 9));
            if (c == 9) req = '0;
        end

        // All four requesters, one tick each, served in order
        start_seq();
        req = 4'hf;
        req_ticks = {4{8'd1}};
        for (int c = 1; c <= 24; c++) begin
            adv(1);
            for (int i = 0; i < N; i++) begin
                int s;
                s = 1 + 6 * i;
                chk("t3_gnt", int'(gnt[i]), int'(c >= s && c <= s + 3));
                chk("t3_done", int'(done[i]), int'(c == s + 4));
                if (c == s + 4) req[i] = 1'b0;
            end
        end

        // Zero-tick request
        start_seq();
        req = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            adv(1);
            chk("t4_tick", int'(tick), 0);
            if (c == 1) chk("t4_gnt", int'(gnt), 4'b0010);
            if (c == 2) begin
                chk("t4_done", int'(done), 4'b0010);
                chk("t4_gnt_off", int'(gnt), 0);
                req = '0;
            end
        end

        // Abort by owner while another waits
        start_seq();
        req = 4'b1100;
        req_ticks[23:16] = 8'd5;
        req_ticks[31:24] = 8'd1;
        for (int c = 1; c <= 12; c++) begin
            adv(1);
            chk("t5_no_done2", int'(done[2]), 0);
            if (c == 6) begin
                chk("t5_gnt2", int'(gnt), 4'b0100);
                req[2] = 1'b0;
            end
            if (c == 7) chk("t5_gnt_low", int'(gnt), 0);
            if (c == 8) chk("t5_gnt3", int'(gnt), 4'b1000);
            if (c == 12) begin
                chk("t5_done3", int'(done), 4'b1000);
                req = '0;
            end
        end

        // Three ticks, status visible when enabled
        start_seq();
        req = 4'b0100;
        req_ticks[23:16] = 8'd3;
        for (int c = 1; c <= 13; c++) begin
            adv(1);
            if (c == 12) chk("t6_gnt_last", int'(gnt), 4'b0100);
            if (c == 13) begin
                chk("t6_done", int'(done), 4'b0100);
                req = '0;
            end
`ifdef TIMER_SHARE_STATUS_EN
            if (c == 1) chk("t6_owner", int'(owner), 2);
            if (c == 4) chk("t6_rem3", int'(remaining), 3);
            if (c == 5) chk("t6_rem2", int'(remaining), 2);
            if (c == 9) chk("t6_rem1", int'(remaining), 1);
`endif
        end

        // Held requests alternate round robin
        start_seq();
        req = 4'b0011;
        for (int c = 1; c <= 10; c++) begin
            adv(1);
            if (c == 4) chk("t7_gnt1", int'(gnt), 4'b0010);
            if (c == 7) chk("t7_gnt0", int'(gnt), 4'b0001);
            if (c == 10) chk("t7_gnt1b", int'(gnt), 4'b0010);
        end
        req = '0;
        adv(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
